// File: rtl/booth8_pkg.sv
// Shared types and helpers for the sequential radix-8 Booth multiplier.
package booth8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        ITER = 2'd2,
        DONE = 2'd3
    } state_t;

    // One-hot magnitude (1/2/3/4 times A) plus sign of a recoded digit
    typedef struct packed {
        logic neg;
        logic q;
        logic t;
        logic d;
        logic s;
    } digit_sel_t;

    function automatic int num_digits(input int n);
        return (n + 2) / 3;
    endfunction

endpackage

// File: rtl/booth8_digit_sel.sv
// Radix-8 Booth recoder: maps a 4-bit multiplier window to the signed multiple of A.
module booth8_digit_sel
    import booth8_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [3:0]          win,
    input  logic [N-1:0]        a,
    input  logic [N+1:0]        a3,
    output logic signed [N+2:0] sel
);

    digit_sel_t  ds;
    logic [N+2:0] mag;

    always_comb begin
        ds     = '0;
        ds.neg = win[3];
        case (win)
            4'b0001, 4'b0010, 4'b1101, 4'b1110: ds.s = 1'b1;
            4'b0011, 4'b0100, 4'b1011, 4'b1100: ds.d = 1'b1;
            4'b0101, 4'b0110, 4'b1001, 4'b1010: ds.t = 1'b1;
            4'b0111, 4'b1000:                   ds.q = 1'b1;
            default: ;
        endcase
    end

    // Zero magnitude stays zero after negation, so 4'b1111 needs no special case
    always_comb begin
        mag = '0;
        if (ds.s)
            mag = {{3{a[N-1]}}, a};
        else if (ds.d)
            mag = {{2{a[N-1]}}, a, 1'b0};
        else if (ds.t)
            mag = {a3[N+1], a3};
        else if (ds.q)
            mag = {a[N-1], a, 2'b00};
        sel = ds.neg ? -mag : mag;
    end

endmodule

// File: rtl/booth8_seq_ctrl.sv
// Iterative signed radix-8 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Optional EARLY_TERM_EN: stop as soon as the remaining multiplier digits are all zero.
module booth8_seq_ctrl
    import booth8_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     a,
    input  logic [DATA_WIDTH-1:0]     b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_WIDTH-1:0]   product,
    output logic                      busy
);

    localparam int N    = DATA_WIDTH;
    localparam int ND   = num_digits(N);
    localparam int CW   = (ND > 1) ? $clog2(ND) : 1;
    localparam int ACCW = 2 * N + 3;
    localparam int QW   = N + 4;

    state_t          state, state_nxt;
    logic [N-1:0]    a_reg;
    logic [N+1:0]    a3_reg;
    logic [QW-1:0]   q_reg;
    logic [ACCW-1:0] acc, acc_nxt, sel_ext, term;
    logic [CW-1:0]   cnt;
    logic signed [N+2:0] sel;
    logic            last_digit;
    int              shamt;

    // q_reg shifts right by one digit per ITER cycle, so the current window is always its low nibble
    booth8_digit_sel #(.N(N)) u_digit_sel (
        .win (q_reg[3:0]),
        .a   (a_reg),
        .a3  (a3_reg),
        .sel (sel)
    );

    always_comb begin
        shamt   = 3 * int'(cnt);
        sel_ext = {{(ACCW-N-3){sel[N+2]}}, sel};
        term    = sel_ext << shamt;
        acc_nxt = acc + term;
`ifdef EARLY_TERM_EN
        // Remaining windows are all-zero or all-one (digit 0) once the unread bits match the sign
        last_digit = (cnt == CW'(ND - 1)) || (q_reg[QW-1:3] == '0) || (&q_reg[QW-1:3]);
`else
        last_digit = (cnt == CW'(ND - 1));
`endif
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid)
                    state_nxt = PRE;
            end
            PRE:  state_nxt = ITER;
            ITER: if (last_digit) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg   <= '0;
            a3_reg  <= '0;
            q_reg   <= '0;
            acc     <= '0;
            cnt     <= '0;
            product <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    a_reg <= a;
                    q_reg <= {{3{b[N-1]}}, b, 1'b0};
                    acc   <= '0;
                    cnt   <= '0;
                end
                PRE: a3_reg <= {{2{a_reg[N-1]}}, a_reg} + {a_reg[N-1], a_reg, 1'b0};
                ITER: begin
                    acc   <= acc_nxt;
                    cnt   <= cnt + 1'b1;
                    q_reg <= {{3{q_reg[QW-1]}}, q_reg[QW-1:3]};
                    if (last_digit)
                        product <= acc_nxt[2*N-1:0];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth8_seq_ctrl.sv
// Directed and random bench for booth8_seq_ctrl (N=8) against a plain a*b reference.
module tb_booth8_seq_ctrl;

    localparam int N  = 8;
    localparam int ND = (N + 2) / 3;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a;
    logic [N-1:0]  b;
    logic          out_valid;
    logic          out_ready;
    logic [2*N-1:0] product;
    logic          busy;

    int vectors     = 0;
    int miscompares = 0;

    booth8_seq_ctrl #(.DATA_WIDTH(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Number of ITER cycles the multiplier value should take
    function automatic int expectedIters(input logic [N-1:0] bv);
        int iters;
        iters = ND;
`ifdef EARLY_TERM_EN
        for (int i = ND - 1; i >= 0; i--) begin
            int  lo;
            bit  same;
            lo   = (3 * i + 2 < N - 1) ? 3 * i + 2 : N - 1;
            same = 1'b1;
            for (int k = lo; k < N; k++)
                if (bv[k] != bv[N-1]) same = 1'b0;
            if (same) iters = i + 1;
        end
`endif
        return iters;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] ta, input logic [N-1:0] tb_);
        int waitc;
        waitc = 0;
        while (!in_ready && waitc < 20) begin
            @(posedge clk); #1;
            waitc++;
        end
        if (waitc >= 20) checkOutput("accept_wait", in_ready, 1);
        a        = ta;
        b        = tb_;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = N'($urandom);
        b        = N'($urandom);
    endtask

    task automatic waitValid(output int edges);
        edges = 0;
        while (!out_valid && edges < 20) begin
            @(posedge clk); #1;
            edges++;
        end
    endtask

    task automatic runOp(input logic signed [N-1:0] ta, input logic signed [N-1:0] tb_,
                         input int hold, input string tag);
        logic [2*N-1:0] expp;
        int explat;
        int edges;
        expp      = (2*N)'(int'(ta) * int'(tb_));
        explat    = expectedIters(tb_) + 1;
        out_ready = (hold == 0);
        applyStimulus(ta, tb_);
        waitValid(edges);
        checkOutput({tag, "_latency"}, 64'(edges), 64'(explat));
        checkOutput({tag, "_product"}, product, expp);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            checkOutput({tag, "_held_valid"}, out_valid, 1);
            checkOutput({tag, "_held_product"}, product, expp);
            checkOutput({tag, "_held_inready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput({tag, "_release_valid"}, out_valid, 0);
        checkOutput({tag, "_release_inready"}, in_ready, 1);
    endtask

    initial begin
        int edges;
        bit seen;
        clk       = 1'b0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_inready", in_ready, 1);
        checkOutput("reset_outvalid", out_valid, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_product", product, 0);
        rst = 1'b1;

        runOp(8'sd7, 8'sd5, 0, "dir_7x5");
        runOp(-8'sd128, -8'sd128, 0, "dir_min_x_min");
        runOp(-8'sd1, 8'sd127, 0, "dir_m1x127");
        runOp(8'sd0, -8'sd77, 0, "dir_0xm77");
        runOp(8'sd9, 8'sd1, 0, "dir_9x1");
        runOp(8'sd9, -8'sd1, 0, "dir_9xm1");
        runOp(8'sd9, 8'sd127, 0, "dir_9x127");

        runOp(-8'sd128, -8'sd128, 10, "backpressure");

        // A pending input during DONE must not be accepted until IDLE is reached
        out_ready = 1'b0;
        applyStimulus(8'sd3, 8'sd4);
        waitValid(edges);
        checkOutput("done_first_product", product, 16'd12);
        a         = 8'd5;
        b         = 8'd6;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("done_noaccept_busy", busy, 0);
        checkOutput("done_noaccept_inready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("idle_accept_busy", busy, 1);
        waitValid(edges);
        checkOutput("idle_accept_product", product, 16'd30);
        @(posedge clk); #1;

        // Reset while an operation is in ITER
        applyStimulus(8'sd33, -8'sd45);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checkOutput("midrst_outvalid", out_valid, 0);
        checkOutput("midrst_inready", in_ready, 1);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_product", product, 0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        checkOutput("midrst_no_emit", seen, 0);
        runOp(8'sd33, -8'sd45, 0, "after_rst");

        for (int i = 0; i < 1500; i++) begin
            logic signed [N-1:0] ra, rb;
            ra = N'($urandom);
            rb = N'($urandom);
            runOp(ra, rb, $urandom_range(0, 2), "random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
